// File: rtl/bios_load_pkg.sv
// Shared FSM encoding and default sizing for the BIOS load sink.
package bios_load_pkg;

    localparam int BIOS_WORDS  = 4096;
    localparam int BIOS_ADDR_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. It exposes the head word and the free-entry count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == LP_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_free  = LP_DEPTH - r_count;
    assign o_dout  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers and occupancy. Flush wins over any same-cycle push or pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage array. It has no reset because the contents are only observed through valid entries.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/bios_load_sink.sv
// This block receives a sequentially addressed BIOS image from a loader.
// It buffers the words and streams them to memory, keeping a count and a checksum.
module bios_load_sink
    import bios_load_pkg::*;
#(
    parameter int WORDS      = BIOS_WORDS,
    parameter int ADDR_W     = BIOS_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] bios_addr,
    input  logic [15:0]       bios_din,
    input  logic              bios_wr,
    output logic              bios_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum,
    output logic [ADDR_W:0]   word_count
);

    localparam int FW = ADDR_W + 16;
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] LP_WORDS = (ADDR_W+1)'(WORDS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_bios_req;
    logic [15:0]     r_checksum;
    logic [ADDR_W:0] r_count;

    logic            w_room;
    logic            w_addr_ok;
    logic            w_wr_live;
    logic            w_push;
    logic            w_pop;
    logic            w_err;
    logic            w_start;
    logic            w_flush;
    logic            w_full;
    logic            w_empty;
    logic            w_mem_we;
    logic [CW:0]     w_free;
    logic [FW-1:0]   w_head;

    assign w_room    = (r_count < LP_WORDS);
    assign w_addr_ok = (bios_addr == r_count[ADDR_W-1:0]);
    assign w_wr_live = (r_state == ST_RECV) && bios_wr && w_room;
    assign w_flush   = w_start || w_err;
    assign w_mem_we  = ((r_state == ST_RECV) || (r_state == ST_DRAIN)) && !w_empty;
    assign w_pop     = w_mem_we && mem_ready;

    assign mem_we     = w_mem_we;
    assign mem_addr   = w_mem_we ? w_head[FW-1:16] : '0;
    assign mem_data   = w_mem_we ? w_head[15:0]    : '0;
    assign bios_req   = r_bios_req;
    assign busy       = (r_state == ST_RECV) || (r_state == ST_DRAIN);
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERR);
    assign checksum   = r_checksum;
    assign word_count = r_count;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_din   ({bios_addr, bios_din}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_free  (w_free)
    );

    // Next-state logic and word acceptance.
    // A write that arrives while the FIFO is full, or that carries an out-of-order address, aborts the load.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_err       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_state_nxt = ST_RECV;
                    w_start     = 1'b1;
                end
            end
            ST_RECV: begin
                if (w_wr_live) begin
                    if (w_full || !w_addr_ok) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_push = 1'b1;
                    end
                end else if (!w_room) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Count and checksum of accepted words, plus the registered request.
    // Requiring 2 free entries leaves room for a word the loader issues before it sees the request drop.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_checksum <= '0;
            r_bios_req <= 1'b0;
        end else begin
            if (w_start) begin
                r_count    <= '0;
                r_checksum <= '0;
            end else if (w_push) begin
                r_count    <= r_count + 1'b1;
                r_checksum <= r_checksum + bios_din;
            end
            r_bios_req <= (r_state == ST_RECV) && (w_free >= (CW+1)'(2)) && w_room;
        end
    end

endmodule

// File: tb/tb_bios_load_sink.sv
// Scoreboard bench for bios_load_sink.
// The loader pushes each word it expects the sink to accept, and a monitor checks every memory write against that queue.
module tb_bios_load_sink;
    import bios_load_pkg::*;

    localparam int AW = 13;
    localparam int W  = 4096;
    localparam int D  = 4;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] bios_addr = '0;
    logic [15:0]   bios_din = '0;
    logic          bios_wr = 1'b0;
    logic          bios_req;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_we;
    logic          mem_ready = 1'b0;
    logic          busy, done, error;
    logic [15:0]   checksum;
    logic [AW:0]   word_count;

    bios_load_sink #(.WORDS(W), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start),
        .bios_addr(bios_addr), .bios_din(bios_din), .bios_wr(bios_wr),
        .bios_req(bios_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_ready(mem_ready), .busy(busy), .done(done),
        .error(error), .checksum(checksum), .word_count(word_count)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_bad = 0;
    logic [AW+15:0] exp_q[$];
    logic [AW+15:0] mon_e;
    int rdy_mode = 0;   // 0: always ready, N>0: ready 1 of N cycles, <0: never
    int cyc = 0;
    bit bp_chk = 1'b0;
    int occ_cur = 0, occ_prev = 0, req_viol = 0, req_low = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Memory-side readiness pattern
    initial forever begin
        tick();
        cyc++;
        mem_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode < 0) ? 1'b0 : ((cyc % rdy_mode) == 0);
    end

    // Monitor: every memory write that will be taken is compared with the oldest expected word
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (mem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, want no write", mem_addr, mem_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mem_write", {mem_addr, mem_data}, mon_e);
                end
            end
            if (bp_chk) begin
                if (bios_req && occ_prev > D - 2) req_viol++;
                if (!bios_req) req_low++;
                occ_prev = occ_cur;
                occ_cur  = occ_cur + int'(bios_wr) - int'(mem_we && mem_ready);
            end
        end
    end

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Send n words (value i at address i). Word bad_idx gets address i+1. Only words below keep_n are expected to be written.
    task automatic do_load(input int n, input bit gated, input int bad_idx, input int keep_n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 30000) begin
            tick();
            guard++;
            if (!gated || bios_req) begin
                bios_wr   = 1'b1;
                bios_addr = AW'((i == bad_idx) ? i + 1 : i);
                bios_din  = 16'(i);
                if (i < keep_n) exp_q.push_back({AW'(i), 16'(i)});
                i++;
            end else begin
                bios_wr = 1'b0;
            end
        end
        tick();
        bios_wr = 1'b0;
        chk("words_sent", i, n);
    endtask

    task automatic wait_end();
        int k = 0;
        while (!done && !error && k < 100) begin
            tick();
            k++;
        end
        chk("end_reached", (k < 100), 1);
        @(negedge clk_sys);
    endtask

    task automatic chk_full_done(input string p);
        wait_end();
        chk({p, "_done"}, done, 1);
        chk({p, "_error"}, error, 0);
        chk({p, "_checksum"}, checksum, 16'hF800);
        chk({p, "_count"}, word_count, W);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_we"}, mem_we, 0);
        chk({p, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req"}, bios_req, 0);
        chk({p, "_we"}, mem_we, 0);
        chk({p, "_addr"}, mem_addr, 0);
        chk({p, "_data"}, mem_data, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_error"}, error, 0);
        chk({p, "_checksum"}, checksum, 0);
        chk({p, "_count"}, word_count, 0);
    endtask

    initial begin
        #3;
        chk_reset("por");
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Full load, memory always ready
        rdy_mode = 0;
        pulse_start();
        do_load(W, 1'b1, -1, W);
        chk_full_done("full");

        // Restart from DONE
        pulse_start();
        @(negedge clk_sys);
        chk("restart_done", done, 0);
        chk("restart_checksum", checksum, 0);
        chk("restart_count", word_count, 0);
        chk("restart_busy", busy, 1);
        do_load(W, 1'b1, -1, W);
        chk_full_done("reload");

        // Backpressure: ready 1 of 4 cycles, loader gated by bios_req
        rdy_mode = 4;
        pulse_start();
        occ_cur  = 0;
        occ_prev = 0;
        bp_chk   = 1'b1;
        do_load(W, 1'b1, -1, W);
        chk_full_done("bp");
        bp_chk = 1'b0;
        chk("bp_req_vs_free", req_viol, 0);
        chk("bp_req_dropped", (req_low > 0), 1);

        // Address mismatch on word 5
        rdy_mode = 0;
        pulse_start();
        do_load(6, 1'b0, 5, 5);
        @(negedge clk_sys);
        chk("mis_error", error, 1);
        chk("mis_we", mem_we, 0);
        chk("mis_count", word_count, 5);
        chk("mis_checksum", checksum, 10);
        chk("mis_done", done, 0);
        repeat (3) tick();
        @(negedge clk_sys);
        chk("mis_we_later", mem_we, 0);
        chk("mis_busy", busy, 0);
        chk("mis_q_empty", exp_q.size(), 0);

        // Overflow: memory stalled, loader ignores bios_req
        rdy_mode = -1;
        pulse_start();
        do_load(4, 1'b0, -1, 4);
        @(negedge clk_sys);
        chk("ovf_we_full", mem_we, 1);
        chk("ovf_head", {mem_addr, mem_data}, 0);
        chk("ovf_count4", word_count, 4);
        chk("ovf_no_error_yet", error, 0);
        tick();
        bios_wr = 1'b1;
        bios_addr = AW'(4);
        bios_din = 16'd4;
        tick();
        bios_wr = 1'b0;
        @(negedge clk_sys);
        chk("ovf_error", error, 1);
        chk("ovf_count", word_count, 4);
        chk("ovf_checksum", checksum, 6);
        chk("ovf_we", mem_we, 0);
        exp_q.delete();

        // Reset in the middle of a backpressured load
        rdy_mode = 4;
        pulse_start();
        do_load(100, 1'b1, -1, 100);
        chk("mid_busy_before", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("mid");
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clk_sys);
        chk("mid_we_after", mem_we, 0);
        chk("mid_busy_after", busy, 0);
        rdy_mode = 0;
        pulse_start();
        do_load(W, 1'b1, -1, W);
        chk_full_done("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bios_load_sink.md
BIOS_LOAD_SINK -- requirements
Module: bios_load_sink

Interface
REQ-001 SHALL have parameter WORDS, default 4096: number of 16-bit BIOS words per load.
REQ-002 SHALL have parameter ADDR_W, default 13: word address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: depth of the word buffer, power of two, minimum 4.
REQ-004 SHALL have port clk_sys, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a load.
REQ-007 SHALL have port bios_addr, input, ADDR_W bits: word address from the loader.
REQ-008 SHALL have port bios_din, input, 16 bits: word data from the loader.
REQ-009 SHALL have port bios_wr, input, 1 bit: word strobe from the loader.
REQ-010 SHALL have port bios_req, output, 1 bit: sink can take more words.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: memory write address.
REQ-012 SHALL have port mem_data, output, 16 bits: memory write data.
REQ-013 SHALL have port mem_we, output, 1 bit: memory write valid.
REQ-014 SHALL have port mem_ready, input, 1 bit: memory accepts the current write.
REQ-015 SHALL have port busy, output, 1 bit: high while in RECV or DRAIN.
REQ-016 SHALL have port done, output, 1 bit: load completed without error (sticky).
REQ-017 SHALL have port error, output, 1 bit: load aborted (sticky).
REQ-018 SHALL have port checksum, output, 16 bits: modulo-2^16 sum of accepted words.
REQ-019 SHALL have port word_count, output, ADDR_W+1 bits: number of words accepted.

Function
REQ-020 SHALL implement FSM states IDLE, RECV, DRAIN, DONE, ERR; start moves IDLE/DONE/ERR to RECV and clears the FIFO, word_count, checksum, done and error; start is ignored in RECV and DRAIN.
REQ-021 SHALL drive bios_req = (state==RECV) && (free FIFO entries >= 2) && (word_count < WORDS), registered, so words issued during the 1-cycle request-drop latency are still absorbed.
REQ-022 SHALL accept a word in RECV on every clk_sys edge with bios_wr=1 while the FIFO is not full and word_count<WORDS, regardless of bios_req; accepting pushes {bios_addr,bios_din}, increments word_count and adds bios_din to checksum.
REQ-023 SHALL require the accepted bios_addr to equal the low ADDR_W bits of word_count; a mismatch pushes nothing and enters ERR.
REQ-024 SHALL treat bios_wr in RECV with the FIFO full as overflow: drop the word and enter ERR.
REQ-025 SHALL ignore bios_wr in IDLE, DRAIN, DONE and ERR, and in RECV once word_count==WORDS.
REQ-026 SHALL present the FIFO head on mem_addr/mem_data with mem_we=1 whenever the FIFO is non-empty in RECV or DRAIN; a pop occurs only when mem_we && mem_ready; head outputs SHALL stay stable until popped.
REQ-027 SHALL, for simultaneous push and pop, update occupancy by zero with no loss; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 SHALL go RECV->DRAIN the cycle after word_count reaches WORDS, and DRAIN->DONE the cycle after the last pop; done is set on entry to DONE.
REQ-029 SHALL, on entry to ERR, set error, flush the FIFO and drive mem_we=0 from the next cycle.
REQ-030 SHALL keep mem_we=0 in IDLE, DONE and ERR.

Reset
REQ-031 SHALL, on reset_n low, immediately force state=IDLE, FIFO empty, bios_req=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, error=0, checksum=0, word_count=0, including mid-load; no partial write completes afterwards.

Structure
REQ-032 SHALL place the FSM state enum and the default WORDS/ADDR_W constants in a shared package bios_load_pkg.
REQ-033 SHALL implement the buffer as one sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/free count).

Verification
REQ-034 SHALL cover full load: start, 4096 sequential words of value i, mem_ready=1 -> 4096 writes in address order, done=1, checksum=0xF800, word_count=4096.
REQ-035 SHALL cover backpressure: mem_ready toggling 1-of-4 cycles, loader writing every cycle gated by bios_req -> no drops, no error, bios_req low while free<2.
REQ-036 SHALL cover address mismatch: word 5 sent with bios_addr=6 -> error=1 next cycle, mem_we=0 afterwards, word_count=5.
REQ-037 SHALL cover overflow: mem_ready=0, loader ignoring bios_req, 5 writes -> first 4 buffered, 5th sets error.
REQ-038 SHALL cover reset mid-load: reset_n low after 100 words -> all outputs at reset values asynchronously; start then reloads cleanly.
REQ-039 SHALL cover restart: start in DONE -> done cleared, checksum=0, second full load gives identical checksum.
